// File: rtl/hazard_ctrl_if.sv
// Forward-select / stall interface between the D-stage decoder and hazard_ctrl.
// hazard_ctrl drives through the master modport; the decoder/datapath side uses slave.
interface hazard_ctrl_if;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic [1:0] tuse_rs_d;
  logic [1:0] tuse_rt_d;
  logic [4:0] a3_d;
  logic [1:0] src_d;
  logic       md_start_d;
  logic       md_div_d;
  logic       md_use_d;
  logic [2:0] fwd_rs_d;
  logic [2:0] fwd_rt_d;
  logic [2:0] fwd_rs_e;
  logic [2:0] fwd_rt_e;
  logic [2:0] fwd_rt_m;
  logic       stall;

  modport master (
    input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, a3_d, src_d,
    input  md_start_d, md_div_d, md_use_d,
    output fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, stall
  );

  modport slave (
    output rs_d, rt_d, tuse_rs_d, tuse_rt_d, a3_d, src_d,
    output md_start_d, md_div_d, md_use_d,
    input  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, stall
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline: Tnew tracking in E/M/W,
// forward selects and stall. Optional HI/LO busy tracking enabled by macro HAZARD_MDU_EN.
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.master hz
);

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_ALU  = 2'd1;
  localparam logic [1:0] SRC_DM   = 2'd2;
  localparam logic [1:0] SRC_PC8  = 2'd3;

  localparam logic [2:0] FWD_NONE  = 3'd0;
  localparam logic [2:0] FWD_AO_M  = 3'd1;
  localparam logic [2:0] FWD_WD    = 3'd2;
  localparam logic [2:0] FWD_PC8_E = 3'd3;
  localparam logic [2:0] FWD_PC8_M = 3'd4;
  localparam logic [2:0] FWD_PC8_W = 3'd5;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] src;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } e_stage_t;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] src;
    logic [1:0] tnew;
    logic [4:0] rt;
  } m_stage_t;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] src;
    logic [1:0] tnew;
  } w_stage_t;

  e_stage_t e_q, e_d;
  m_stage_t m_q, m_d;
  w_stage_t w_q, w_d;

  logic [1:0] tnew_d;
  logic       stall_rs;
  logic       stall_rt;
  logic       stall_md;
  logic       stall;

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic reg_match(input logic [4:0] a3, input logic [4:0] r);
    return (r != 5'd0) && (a3 == r);
  endfunction

  function automatic logic gpr_stall(input logic [4:0] r, input logic [1:0] tuse,
                                     input logic [4:0] a3_e, input logic [1:0] tnew_e,
                                     input logic [4:0] a3_m, input logic [1:0] tnew_m);
    return (tuse != TUSE_NONE) &&
           ((reg_match(a3_e, r) && (tuse < tnew_e)) ||
            (reg_match(a3_m, r) && (tuse < tnew_m)));
  endfunction

  // Nearest eligible stage wins; callers disable stages they cannot source from.
  function automatic logic [2:0] pick_fwd(input logic el_e, input logic [1:0] s_e,
                                          input logic el_m, input logic [1:0] s_m,
                                          input logic el_w, input logic [1:0] s_w);
    logic [2:0] f;
    f = FWD_NONE;
    if (el_e && (s_e == SRC_PC8))
      f = FWD_PC8_E;
    else if (el_m && (s_m == SRC_ALU))
      f = FWD_AO_M;
    else if (el_m && (s_m == SRC_PC8))
      f = FWD_PC8_M;
    else if (el_w && ((s_w == SRC_ALU) || (s_w == SRC_DM)))
      f = FWD_WD;
    else if (el_w && (s_w == SRC_PC8))
      f = FWD_PC8_W;
    return f;
  endfunction

  always_comb begin
    tnew_d = 2'd0;
    case (hz.src_d)
      SRC_ALU: tnew_d = 2'd1;
      SRC_DM:  tnew_d = 2'd2;
      default: tnew_d = 2'd0;
    endcase
  end

  always_comb begin
    stall_rs = gpr_stall(hz.rs_d, hz.tuse_rs_d, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew);
    stall_rt = gpr_stall(hz.rt_d, hz.tuse_rt_d, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew);
    stall    = stall_rs | stall_rt | stall_md;
  end

  // Pipeline advance; W also decrements so a load has Tnew 0 once its data is in WD.
  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.a3   = hz.a3_d;
      e_d.src  = hz.src_d;
      e_d.tnew = tnew_d;
      e_d.rs   = hz.rs_d;
      e_d.rt   = hz.rt_d;
    end
    m_d.a3   = e_q.a3;
    m_d.src  = e_q.src;
    m_d.tnew = dec_sat(e_q.tnew);
    m_d.rt   = e_q.rt;
    w_d.a3   = m_q.a3;
    w_d.src  = m_q.src;
    w_d.tnew = dec_sat(m_q.tnew);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  logic el_rs_d_e, el_rs_d_m, el_rs_d_w;
  logic el_rt_d_e, el_rt_d_m, el_rt_d_w;
  logic el_rs_e_m, el_rs_e_w, el_rt_e_m, el_rt_e_w;
  logic el_rt_m_w;

  always_comb begin
    el_rs_d_e = reg_match(e_q.a3, hz.rs_d) && (e_q.tnew == 2'd0);
    el_rs_d_m = reg_match(m_q.a3, hz.rs_d) && (m_q.tnew == 2'd0);
    el_rs_d_w = reg_match(w_q.a3, hz.rs_d) && (w_q.tnew == 2'd0);
    el_rt_d_e = reg_match(e_q.a3, hz.rt_d) && (e_q.tnew == 2'd0);
    el_rt_d_m = reg_match(m_q.a3, hz.rt_d) && (m_q.tnew == 2'd0);
    el_rt_d_w = reg_match(w_q.a3, hz.rt_d) && (w_q.tnew == 2'd0);
    el_rs_e_m = reg_match(m_q.a3, e_q.rs) && (m_q.tnew == 2'd0);
    el_rs_e_w = reg_match(w_q.a3, e_q.rs) && (w_q.tnew == 2'd0);
    el_rt_e_m = reg_match(m_q.a3, e_q.rt) && (m_q.tnew == 2'd0);
    el_rt_e_w = reg_match(w_q.a3, e_q.rt) && (w_q.tnew == 2'd0);
    el_rt_m_w = reg_match(w_q.a3, m_q.rt) && (w_q.tnew == 2'd0);
  end

  assign hz.fwd_rs_d = pick_fwd(el_rs_d_e, e_q.src, el_rs_d_m, m_q.src, el_rs_d_w, w_q.src);
  assign hz.fwd_rt_d = pick_fwd(el_rt_d_e, e_q.src, el_rt_d_m, m_q.src, el_rt_d_w, w_q.src);
  assign hz.fwd_rs_e = pick_fwd(1'b0, SRC_NONE, el_rs_e_m, m_q.src, el_rs_e_w, w_q.src);
  assign hz.fwd_rt_e = pick_fwd(1'b0, SRC_NONE, el_rt_e_m, m_q.src, el_rt_e_w, w_q.src);
  assign hz.fwd_rt_m = pick_fwd(1'b0, SRC_NONE, 1'b0, SRC_NONE, el_rt_m_w, w_q.src);
  assign hz.stall    = stall;

`ifdef HAZARD_MDU_EN
  logic [3:0] md_cnt_q, md_cnt_d;
  logic       md_e_q, md_e_d;

  // The count holds while the issuing mult/div sits in E, so the busy window
  // covers the E cycle plus the full configured latency.
  always_comb begin
    md_e_d   = hz.md_start_d & ~stall;
    md_cnt_d = md_cnt_q;
    if (hz.md_start_d && !stall)
      md_cnt_d = hz.md_div_d ? 4'(DIV_CYC) : 4'(MULT_CYC);
    else if (!md_e_q && (md_cnt_q != 4'd0))
      md_cnt_d = md_cnt_q - 4'd1;
    stall_md = hz.md_use_d && ((md_cnt_q != 4'd0) || md_e_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt_q <= 4'd0;
      md_e_q   <= 1'b0;
    end else begin
      md_cnt_q <= md_cnt_d;
      md_e_q   <= md_e_d;
    end
  end
`else
  logic unused_md;
  assign unused_md = &{1'b0, hz.md_start_d, hz.md_div_d, hz.md_use_d};
  assign stall_md  = 1'b0;
`endif

endmodule
